// File: rtl/layer_mux_pkg.sv
// Shared types and helpers for the layer_mux frame-synchronous channel mux.
// Holds the selection FSM state type and the select-width helper.
package layer_mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    // Select width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_mux_sel_fsm.sv
// Request / pending / active channel selection for layer_mux.
// Requests wait in a pending slot until a frame strobe applies them.
module layer_mux_sel_fsm
    import layer_mux_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int RST_SEL = 0,
    parameter int SEL_W   = clog2_min1(NUM_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] sel_in_i,
    input  logic             sel_load_i,
    input  logic             frame_strobe_i,
    output logic [SEL_W-1:0] active_sel_o,
    output logic             pending_o,
    output logic             sel_err_o
);

    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

    state_e           state_q;
    logic [SEL_W-1:0] pend_sel_q;
    logic [SEL_W-1:0] active_sel_q;
    logic             sel_err_q;
    logic             legal;

    // A request is legal only if it names an existing channel.
    always_comb begin
        legal = ({1'b0, sel_in_i} < NUM_CH_W);
    end

    // Selection FSM: capture requests, apply the held one on frame strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_sel_q   <= '0;
            active_sel_q <= SEL_W'(RST_SEL);
            sel_err_q    <= 1'b0;
        end else begin
            sel_err_q <= sel_load_i & ~legal;
            unique case (state_q)
                IDLE: begin
                    if (sel_load_i && legal) begin
                        pend_sel_q <= sel_in_i;
                        state_q    <= PEND;
                    end
                end
                PEND: begin
                    if (frame_strobe_i) begin
                        active_sel_q <= pend_sel_q;
                        if (sel_load_i && legal) begin
                            pend_sel_q <= sel_in_i;
                            state_q    <= PEND;
                        end else begin
                            state_q    <= IDLE;
                        end
                    end else if (sel_load_i && legal) begin
                        pend_sel_q <= sel_in_i;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign active_sel_o = active_sel_q;
    assign pending_o    = (state_q == PEND);
    assign sel_err_o    = sel_err_q;

endmodule

// File: rtl/layer_mux.sv
// Registered N-channel layer mux with frame-synchronous selection switching.
// Optional macro LAYER_MUX_PRIO_EN adds prio_mode (lowest valid channel wins).
module layer_mux
    import layer_mux_pkg::*;
#(
    parameter int                NUM_CH  = 4,
    parameter int                WIDTH   = 8,
    parameter logic [WIDTH-1:0]  DEFAULT = '0,
    parameter int                RST_SEL = 0,
    localparam int               SEL_W   = clog2_min1(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] din,
    input  logic [NUM_CH-1:0]       din_valid,
    input  logic [SEL_W-1:0]        sel_in,
    input  logic                    sel_load,
    input  logic                    frame_strobe,
`ifdef LAYER_MUX_PRIO_EN
    input  logic                    prio_mode,
`endif
    output logic [WIDTH-1:0]        q,
    output logic                    q_valid,
    output logic [SEL_W-1:0]        active_sel,
    output logic                    pending,
    output logic                    sel_err
);

    logic [WIDTH-1:0] ch [NUM_CH];
    logic [SEL_W-1:0] src_sel;
    logic             src_valid;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic             q_valid_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch[i] = din[i*WIDTH +: WIDTH];
    end

    layer_mux_sel_fsm #(
        .NUM_CH  (NUM_CH),
        .RST_SEL (RST_SEL),
        .SEL_W   (SEL_W)
    ) u_sel_fsm (
        .clk            (clk),
        .rst            (rst),
        .sel_in_i       (sel_in),
        .sel_load_i     (sel_load),
        .frame_strobe_i (frame_strobe),
        .active_sel_o   (active_sel),
        .pending_o      (pending),
        .sel_err_o      (sel_err)
    );

`ifdef LAYER_MUX_PRIO_EN
    logic [SEL_W-1:0] prio_sel;

    // Lowest-index valid channel; falls back to ch0 (invalid -> DEFAULT).
    always_comb begin
        prio_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (din_valid[i]) prio_sel = SEL_W'(i);
        end
    end

    // Source is the priority pick or the frame-latched selection.
    always_comb begin
        src_sel = prio_mode ? prio_sel : active_sel;
    end
`else
    // Source is always the frame-latched selection.
    always_comb begin
        src_sel = active_sel;
    end
`endif

    // Mux the chosen channel, substituting DEFAULT when it is not valid.
    always_comb begin
        src_valid = din_valid[src_sel];
        q_d       = src_valid ? ch[src_sel] : DEFAULT;
    end

    // Output register: one cycle from selection to q.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= DEFAULT;
            q_valid_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= src_valid;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule

// File: tb/tb_layer_mux.sv
// Self-checking bench for layer_mux: a 4-channel and a 3-channel instance
// share stimulus and are compared every cycle against a request-queue model.
module tb_layer_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic [3:0]  vld;
    logic [1:0]  sel;
    logic        load;
    logic        strobe;
    logic        prio = 1'b0;

    logic [7:0]  q4, q3;
    logic        qv4, qv3;
    logic [1:0]  as4, as3;
    logic        pd4, pd3;
    logic        er4, er3;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    layer_mux #(
        .NUM_CH  (4),
        .WIDTH   (8),
        .DEFAULT (8'h00),
        .RST_SEL (0)
    ) u4 (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .din_valid    (vld),
        .sel_in       (sel),
        .sel_load     (load),
        .frame_strobe (strobe),
`ifdef LAYER_MUX_PRIO_EN
        .prio_mode    (prio),
`endif
        .q            (q4),
        .q_valid      (qv4),
        .active_sel   (as4),
        .pending      (pd4),
        .sel_err      (er4)
    );

    layer_mux #(
        .NUM_CH  (3),
        .WIDTH   (8),
        .DEFAULT (8'h00),
        .RST_SEL (0)
    ) u3 (
        .clk          (clk),
        .rst          (rst),
        .din          (din[23:0]),
        .din_valid    (vld[2:0]),
        .sel_in       (sel),
        .sel_load     (load),
        .frame_strobe (strobe),
`ifdef LAYER_MUX_PRIO_EN
        .prio_mode    (prio),
`endif
        .q            (q3),
        .q_valid      (qv3),
        .active_sel   (as3),
        .pending      (pd3),
        .sel_err      (er3)
    );

    // Model state per instance (0: 4 channels, 1: 3 channels).
    int m_act [2];
    int m_q   [2];
    int m_qv  [2];
    int m_err [2];
    int m_pq  [2][$];

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic model_step(input int k, input int n);
        int s;
        if (rst) begin
            m_act[k] = 0;
            m_q[k]   = 0;
            m_qv[k]  = 0;
            m_err[k] = 0;
            m_pq[k].delete();
        end else begin
            s = m_act[k];
            if (prio) begin
                s = -1;
                for (int i = 0; i < n; i++)
                    if (vld[i] && s < 0) s = i;
            end
            if (s >= 0 && vld[s]) begin
                m_q[k]  = int'(din[s*8 +: 8]);
                m_qv[k] = 1;
            end else begin
                m_q[k]  = 0;
                m_qv[k] = 0;
            end
            m_err[k] = (load && int'(sel) >= n) ? 1 : 0;
            if (strobe && m_pq[k].size() > 0) m_act[k] = m_pq[k].pop_front();
            if (load && int'(sel) < n) begin
                m_pq[k].delete();
                m_pq[k].push_back(int'(sel));
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0, 4);
        model_step(1, 3);
        #1;
        check("u4.q",       int'(q4),  m_q[0]);
        check("u4.q_valid", int'(qv4), m_qv[0]);
        check("u4.active",  int'(as4), m_act[0]);
        check("u4.pending", int'(pd4), (m_pq[0].size() != 0) ? 1 : 0);
        check("u4.sel_err", int'(er4), m_err[0]);
        check("u3.q",       int'(q3),  m_q[1]);
        check("u3.q_valid", int'(qv3), m_qv[1]);
        check("u3.active",  int'(as3), m_act[1]);
        check("u3.pending", int'(pd3), (m_pq[1].size() != 0) ? 1 : 0);
        check("u3.sel_err", int'(er3), m_err[1]);
    endtask

    initial begin
        rst    = 1'b1;
        din    = {8'h33, 8'h22, 8'h11, 8'hA5};
        vld    = 4'b1111;
        sel    = '0;
        load   = 1'b0;
        strobe = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_q[k] = 0; m_qv[k] = 0; m_err[k] = 0;
        end

        // Reset state
        cycle();
        cycle();
        check("rst.q", int'(q4), 'h00);
        check("rst.q_valid", int'(qv4), 0);
        check("rst.active", int'(as4), 0);
        check("rst.pending", int'(pd4), 0);

        // First sample after release shows channel 0
        rst = 1'b0;
        cycle();
        check("t1.q", int'(q4), 'hA5);
        check("t1.q_valid", int'(qv4), 1);

        // Load 2, strobe five cycles later
        sel = 2'd2; load = 1'b1;
        cycle();
        load = 1'b0;
        check("t2.pending", int'(pd4), 1);
        check("t2.active_hold", int'(as4), 0);
        repeat (4) cycle();
        check("t2.q_hold", int'(q4), 'hA5);
        strobe = 1'b1;
        cycle();
        strobe = 1'b0;
        check("t2.active", int'(as4), 2);
        check("t2.pending_clr", int'(pd4), 0);
        check("t2.q_old", int'(q4), 'hA5);
        cycle();
        check("t2.q_new", int'(q4), 'h22);

        // Last load wins; load+strobe together
        sel = 2'd1; load = 1'b1;
        cycle();
        sel = 2'd3;
        cycle();
        load = 1'b0; strobe = 1'b1;
        cycle();
        strobe = 1'b0;
        check("t3.last_wins", int'(as4), 3);
        sel = 2'd1; load = 1'b1;
        cycle();
        sel = 2'd2; strobe = 1'b1;
        cycle();
        load = 1'b0; strobe = 1'b0;
        check("t3.applied_first", int'(as4), 1);
        check("t3.still_pending", int'(pd4), 1);
        strobe = 1'b1;
        cycle();
        strobe = 1'b0;
        check("t3.applied_second", int'(as4), 2);

        // Invalid selected channel and illegal request on the 3-channel mux
        vld = 4'b1011;
        cycle();
        cycle();
        check("t4.q_default", int'(q3), 'h00);
        check("t4.q_valid0", int'(qv3), 0);
        sel = 2'd3; load = 1'b1;
        cycle();
        load = 1'b0;
        check("t4.sel_err", int'(er3), 1);
        check("t4.no_pending", int'(pd3), 0);
        check("t4.active_kept", int'(as3), 2);
        check("t4.u4_legal", int'(er4), 0);
        cycle();
        check("t4.err_pulse", int'(er3), 0);

        // Reset while pending
        vld = 4'b1111;
        sel = 2'd1; load = 1'b1;
        cycle();
        load = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t5.pending", int'(pd4), 0);
        check("t5.active", int'(as4), 0);
        strobe = 1'b1;
        cycle();
        strobe = 1'b0;
        check("t5.strobe_noop", int'(as4), 0);

`ifdef LAYER_MUX_PRIO_EN
        prio = 1'b1; vld = 4'b1010;
        cycle();
        check("t6.prio_q", int'(q4), 'h11);
        vld = 4'b0000;
        cycle();
        check("t6.prio_none", int'(q4), 'h00);
        check("t6.prio_none_v", int'(qv4), 0);
        prio = 1'b0;
`endif

        // Randomized traffic
        for (int t = 0; t < 3000; t++) begin
            rst    = ($urandom_range(0, 63) == 0);
            load   = ($urandom_range(0, 3) == 0);
            strobe = ($urandom_range(0, 5) == 0);
            sel    = 2'($urandom_range(0, 3));
            din    = $urandom;
            vld    = 4'($urandom_range(0, 15));
`ifdef LAYER_MUX_PRIO_EN
            prio   = ($urandom_range(0, 3) == 0);
`endif
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
